// File: rtl/requant_uint8.sv
// Requantizes 32-bit MAC accumulators to uint8: bias add, scale, arithmetic shift, ReLU/saturate,
// then a small output FIFO guarded by credits. Define REQUANT_ROUNDING_EN for round-half-up shifting.
module requant_uint8 #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [31:0]                     acc_in,
    input  logic                            acc_valid,
    output logic                            acc_ready,
    input  logic [31:0]                     bias,
    input  logic [15:0]                     scale,
    input  logic [5:0]                      shift,
    output logic [7:0]                      out_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
    output logic [15:0]                     sat_count,
    input  logic                            sat_clear
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    // Stage 1: biased sum plus the per-transfer scale/shift that travel with it
    logic               s1_valid_reg;
    logic signed [33:0] s1_sum_reg;
    logic [15:0]        s1_scale_reg;
    logic [5:0]         s1_shift_reg;
    // Stage 2: exact product
    logic               s2_valid_reg;
    logic signed [49:0] s2_prod_reg;
    logic [5:0]         s2_shift_reg;
    // Stage 3: clamped byte ready for the FIFO
    logic               s3_valid_reg;
    logic [7:0]         s3_data_reg;
    logic               s3_sat_reg;

    logic               accept;
    logic signed [33:0] sum_next;
    logic [5:0]         shift_clamped;
    logic signed [50:0] prod_full;
    logic [50:0]        round_add;
    logic signed [50:0] rounded;
    logic signed [50:0] shifted;
    logic [7:0]         data_next;
    logic               sat_next;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;
    logic [15:0]   sat_reg;
    logic          push;
    logic          pop;
    logic [CW+1:0] credit_used;

    assign accept        = acc_valid && acc_ready;
    assign sum_next      = $signed({2'b00, acc_in}) + $signed({{2{bias[31]}}, bias});
    assign shift_clamped = (shift > 6'd47) ? 6'd47 : shift;
    assign prod_full     = s1_sum_reg * $signed({1'b0, s1_scale_reg});

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid_reg <= 1'b0;
            s2_valid_reg <= 1'b0;
            s3_valid_reg <= 1'b0;
        end else begin
            s1_valid_reg <= accept;
            s2_valid_reg <= s1_valid_reg;
            s3_valid_reg <= s2_valid_reg;
        end
    end

    always_ff @(posedge clock) begin
        if (accept) begin
            s1_sum_reg   <= sum_next;
            s1_scale_reg <= scale;
            s1_shift_reg <= shift_clamped;
        end
        s2_prod_reg  <= prod_full[49:0];
        s2_shift_reg <= s1_shift_reg;
        s3_data_reg  <= data_next;
        s3_sat_reg   <= sat_next;
    end

    always_comb begin
        round_add = '0;
`ifdef REQUANT_ROUNDING_EN
        if (s2_shift_reg != 6'd0) begin
            round_add = 51'd1 << (s2_shift_reg - 6'd1);
        end
`endif
        rounded   = $signed({s2_prod_reg[49], s2_prod_reg}) + $signed(round_add);
        shifted   = rounded >>> s2_shift_reg;
        data_next = shifted[7:0];
        sat_next  = 1'b0;
        if (shifted[50]) begin
            data_next = 8'd0;
            sat_next  = 1'b1;
        end else if (|shifted[49:8]) begin
            data_next = 8'd255;
            sat_next  = 1'b1;
        end
    end

    // Credits count FIFO entries plus results still in the pipe, so a push never finds the FIFO full
    assign credit_used = {2'b00, count_reg}
                       + (CW+2)'(s1_valid_reg) + (CW+2)'(s2_valid_reg) + (CW+2)'(s3_valid_reg);
    assign acc_ready   = !reset && (credit_used < (CW+2)'(FIFO_DEPTH));

    assign push       = s3_valid_reg;
    assign out_valid  = (count_reg != '0);
    assign pop        = out_valid && out_ready;
    assign out_data   = out_valid ? mem[rd_ptr_reg] : 8'd0;
    assign fifo_count = count_reg;
    assign sat_count  = sat_reg;

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr_reg] <= s3_data_reg;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            count_reg <= count_next;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || sat_clear) begin
            sat_reg <= 16'd0;
        end else if (push && s3_sat_reg && (sat_reg != 16'hFFFF)) begin
            sat_reg <= sat_reg + 16'd1;
        end
    end
endmodule
